// File: rtl/mem_pkg.sv
// Shared types, encodings and helpers for the EX/MEM memory access unit.
package mem_pkg;

  localparam int unsigned XLEN                   = 64;
  localparam int unsigned STRB_W                 = XLEN / 8;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Request captured at issue and held for the whole bus transaction
  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] wstrb;
    logic              we;
    logic [2:0]        funct3;
  } mem_cmd_t;

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [2:0] lane);
    case (funct3[1:0])
      2'b00:   is_aligned = 1'b1;
      2'b01:   is_aligned = ~lane[0];
      2'b10:   is_aligned = (lane[1:0] == 2'b00);
      default: is_aligned = (lane == 3'b000);
    endcase
  endfunction

  function automatic logic [STRB_W-1:0] store_strb(input logic [2:0] funct3, input logic [2:0] lane);
    case (funct3[1:0])
      2'b00:   store_strb = 8'h01 << lane;
      2'b01:   store_strb = 8'h03 << lane;
      2'b10:   store_strb = 8'h0F << lane;
      default: store_strb = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Doubleword data-memory bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;
  import mem_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_formatter.sv
// Extracts the addressed bytes from a read doubleword and sign/zero-extends them.
module load_formatter
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      lane_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] result_c_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_i >> {lane_i, 3'b000};

  always_comb begin
    result_c_o = shifted;
    case (funct3_i)
      F3_LB:   result_c_o = {{56{shifted[7]}}, shifted[7:0]};
      F3_LH:   result_c_o = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   result_c_o = {{32{shifted[31]}}, shifted[31:0]};
      F3_LBU:  result_c_o = {56'd0, shifted[7:0]};
      F3_LHU:  result_c_o = {48'd0, shifted[15:0]};
      F3_LWU:  result_c_o = {32'd0, shifted[31:0]};
      default: result_c_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: issues one bus transaction per load/store, stalls the
// pipeline until it completes, and reports misaligned/illegal ops and timeouts.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                EX_MEM_valid,
  input  logic                EX_MEM_MemRead,
  input  logic                EX_MEM_MemWrite,
  input  logic [2:0]          EX_MEM_funct3,
  input  logic [XLEN-1:0]     EX_MEM_Result,
  input  logic [XLEN-1:0]     EX_MEM_WriteData,
  mem_access_unit_if.master   bus,
  output logic [XLEN-1:0]     Read_Data,
  output logic                mem_stall,
  output logic                access_fault,
  output logic                bus_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_cmd_t        cmd_q, cmd_d, cmd_new;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] load_fmt;
  logic            mem_op, op_ok;
  logic            stall_c, fault_c, berr_c;

  assign mem_op = EX_MEM_valid & (EX_MEM_MemRead | EX_MEM_MemWrite);
  assign op_ok  = (EX_MEM_funct3 != 3'b111)
                & ~(EX_MEM_MemWrite & EX_MEM_funct3[2])
                & ~(EX_MEM_MemRead & EX_MEM_MemWrite)
                & is_aligned(EX_MEM_funct3, EX_MEM_Result[2:0]);

  always_comb begin
    cmd_new        = '0;
    cmd_new.addr   = EX_MEM_Result;
    cmd_new.we     = EX_MEM_MemWrite;
    cmd_new.funct3 = EX_MEM_funct3;
    if (EX_MEM_MemWrite) begin
      cmd_new.wdata = EX_MEM_WriteData << {EX_MEM_Result[2:0], 3'b000};
      cmd_new.wstrb = store_strb(EX_MEM_funct3, EX_MEM_Result[2:0]);
    end
  end

  load_formatter u_load_formatter (
    .rdata_i    (bus.mem_rdata),
    .lane_i     (cmd_q.addr[2:0]),
    .funct3_i   (cmd_q.funct3),
    .result_c_o (load_fmt)
  );

  // Next-state, datapath updates and per-cycle status
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    stall_c = 1'b0;
    fault_c = 1'b0;
    berr_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && !op_ok) begin
          fault_c = 1'b1;
          rdata_d = '0;
        end else if (mem_op) begin
          stall_c = 1'b1;
          cmd_d   = cmd_new;
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall_c = 1'b1;
        if (bus.mem_ack) begin
          if (!cmd_q.we) rdata_d = load_fmt;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          berr_c  = 1'b1;
          rdata_d = '0;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // One bubble lets the pipeline advance past the completed instruction
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.mem_req   = (state_q == ST_ACCESS);
  assign bus.mem_we    = cmd_q.we;
  assign bus.mem_addr  = {cmd_q.addr[XLEN-1:3], 3'b000};
  assign bus.mem_wdata = cmd_q.wdata;
  assign bus.mem_wstrb = cmd_q.wstrb;

  assign Read_Data    = rdata_q;
  assign mem_stall    = reset & stall_c;
  assign access_fault = reset & fault_c;
  assign bus_error    = reset & berr_c;

endmodule
